// File: rtl/fwd_hazard_unit.sv
// D-stage operand forwarding and load-use stall unit with a Tnew destination scoreboard.
// Optional stall_cnt output is enabled by defining FWD_HAZARD_STALL_CNT_EN.
module fwd_hazard_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned REG_AW  = 5,
  localparam int unsigned SEL_W  = $clog2(NUM_FWD + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      d_valid,
  input  logic [NUM_RD*REG_AW-1:0]  d_rs_addr,
  input  logic [NUM_RD*2-1:0]       d_tuse,
  input  logic [NUM_RD*DATA_W-1:0]  d_rd_data,
  input  logic                      d_wr_en,
  input  logic [REG_AW-1:0]         d_wr_addr,
  input  logic [1:0]                d_tnew,
  input  logic                      e_flush,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic [NUM_RD*DATA_W-1:0]  operand,
  output logic [NUM_RD*SEL_W-1:0]   fwd_sel,
`ifdef FWD_HAZARD_STALL_CNT_EN
  output logic [31:0]               stall_cnt,
`endif
  output logic                      stall
);

  localparam int unsigned TW = 2;

  logic [NUM_FWD-1:0] sb_valid;
  logic [REG_AW-1:0]  sb_wa   [NUM_FWD];
  logic [TW-1:0]      sb_tnew [NUM_FWD];

  logic [NUM_RD-1:0]  hit;
  logic [NUM_RD-1:0]  port_stall;
  logic [SEL_W-1:0]   hit_sel  [NUM_RD];
  logic [TW-1:0]      hit_tnew [NUM_RD];
  logic [DATA_W-1:0]  hit_data [NUM_RD];
  logic               bubble;

  // Youngest-match search: scan oldest to youngest so the smallest k wins.
  // While reset is asserted the scoreboard is treated as already cleared.
  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      hit_sel[i]  = '0;
      hit_tnew[i] = '0;
      hit_data[i] = '0;
      for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
        if (!reset && sb_valid[k]
            && (d_rs_addr[i*REG_AW +: REG_AW] != '0)
            && (sb_wa[k] == d_rs_addr[i*REG_AW +: REG_AW])) begin
          hit[i]      = 1'b1;
          hit_sel[i]  = SEL_W'(k + 1);
          hit_tnew[i] = sb_tnew[k];
          hit_data[i] = fwd_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Per-port resolution: forward a ready value, defer a late-enough one, or stall.
  always_comb begin
    operand    = d_rd_data;
    fwd_sel    = '0;
    port_stall = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      if (hit[i]) begin
        if (hit_tnew[i] == '0) begin
          fwd_sel[i*SEL_W +: SEL_W]   = hit_sel[i];
          operand[i*DATA_W +: DATA_W] = hit_data[i];
        end else if (hit_tnew[i] > d_tuse[i*TW +: TW]) begin
          port_stall[i] = 1'b1;
        end
      end
    end
  end

  assign stall  = d_valid & (|port_stall);
  assign bubble = stall | e_flush | ~d_valid;

  // Scoreboard shift with saturating Tnew countdown; entry 0 takes D or a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_valid <= '0;
      for (int k = 0; k < int'(NUM_FWD); k++) begin
        sb_wa[k]   <= '0;
        sb_tnew[k] <= '0;
      end
    end else begin
      for (int k = int'(NUM_FWD) - 1; k > 0; k--) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_wa[k]    <= sb_wa[k-1];
        sb_tnew[k]  <= (sb_tnew[k-1] == '0) ? '0 : sb_tnew[k-1] - TW'(1);
      end
      if (bubble) begin
        sb_valid[0] <= 1'b0;
        sb_wa[0]    <= '0;
        sb_tnew[0]  <= '0;
      end else begin
        sb_valid[0] <= d_wr_en && (d_wr_addr != '0);
        sb_wa[0]    <= d_wr_addr;
        sb_tnew[0]  <= d_tnew;
      end
    end
  end

`ifdef FWD_HAZARD_STALL_CNT_EN
  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed plus randomized bench for fwd_hazard_unit against an issue-history reference model.
module tb_fwd_hazard_unit;

  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NF = 3;
  localparam int AW = 5;
  localparam int SW = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               d_valid;
  logic [NR*AW-1:0]   d_rs_addr;
  logic [NR*2-1:0]    d_tuse;
  logic [NR*DW-1:0]   d_rd_data;
  logic               d_wr_en;
  logic [AW-1:0]      d_wr_addr;
  logic [1:0]         d_tnew;
  logic               e_flush;
  logic [NF*DW-1:0]   fwd_data;
  logic [NR*DW-1:0]   operand;
  logic [NR*SW-1:0]   fwd_sel;
  logic               stall;
`ifdef FWD_HAZARD_STALL_CNT_EN
  logic [31:0]        stall_cnt;
  logic [31:0]        exp_cnt;
`endif

  fwd_hazard_unit dut (
    .clk       (clk),
    .reset     (reset),
    .d_valid   (d_valid),
    .d_rs_addr (d_rs_addr),
    .d_tuse    (d_tuse),
    .d_rd_data (d_rd_data),
    .d_wr_en   (d_wr_en),
    .d_wr_addr (d_wr_addr),
    .d_tnew    (d_tnew),
    .e_flush   (e_flush),
    .fwd_data  (fwd_data),
    .operand   (operand),
    .fwd_sel   (fwd_sel),
`ifdef FWD_HAZARD_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .stall     (stall)
  );

  always #5 clk = ~clk;

  // Model: instructions accepted into E, most recent first; entry k was accepted k+1 cycles ago.
  typedef struct {
    bit v;
    int wa;
    int t0;
  } rec_t;
  rec_t hist[$];

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_sel [NR];
  logic [DW-1:0] exp_op [NR];
  bit          exp_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hist_clear();
    rec_t r;
    r.v = 0; r.wa = 0; r.t0 = 0;
    hist = {};
    for (int k = 0; k < NF; k++) hist.push_back(r);
  endtask

  // Remaining latency of an instruction decays by one per stage travelled, floored at 0.
  task automatic model_eval();
    bit req;
    req = 0;
    for (int i = 0; i < NR; i++) begin
      int a;
      int u;
      a = int'(d_rs_addr[i*AW +: AW]);
      u = int'(d_tuse[i*2 +: 2]);
      exp_sel[i] = 0;
      exp_op[i]  = d_rd_data[i*DW +: DW];
      if (!reset && a != 0) begin
        for (int k = 0; k < NF; k++) begin
          if (hist[k].v && hist[k].wa == a) begin
            int rem;
            rem = (hist[k].t0 > k) ? hist[k].t0 - k : 0;
            if (rem == 0) begin
              exp_sel[i] = k + 1;
              exp_op[i]  = fwd_data[k*DW +: DW];
            end else if (rem > u) begin
              req = 1;
            end
            break;
          end
        end
      end
    end
    exp_stall = d_valid && req;
  endtask

  task automatic check_all(input string tag);
    model_eval();
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("%s_sel%0d", tag, i), 32'(fwd_sel[i*SW +: SW]), 32'(exp_sel[i]));
      chk($sformatf("%s_op%0d", tag, i), operand[i*DW +: DW], exp_op[i]);
    end
    chk($sformatf("%s_stall", tag), 32'(stall), 32'(exp_stall));
`ifdef FWD_HAZARD_STALL_CNT_EN
    chk($sformatf("%s_cnt", tag), stall_cnt, exp_cnt);
`endif
  endtask

  // Check at the falling edge, then advance the model across the rising edge.
  task automatic step(input string tag);
    rec_t r;
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    if (reset) begin
      hist_clear();
    end else begin
      r.v  = !(exp_stall || e_flush || !d_valid) && d_wr_en && (d_wr_addr != 0);
      r.wa = int'(d_wr_addr);
      r.t0 = int'(d_tnew);
      hist.push_front(r);
      void'(hist.pop_back());
    end
`ifdef FWD_HAZARD_STALL_CNT_EN
    if (reset) exp_cnt = 0;
    else if (exp_stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
`endif
    #1;
  endtask

  task automatic drive(input bit v, input int a0, input int u0, input int a1, input int u1,
                       input bit we, input int wa, input int tn, input bit fl);
    d_valid   = v;
    d_rs_addr = {AW'(a1), AW'(a0)};
    d_tuse    = {2'(u1), 2'(u0)};
    d_wr_en   = we;
    d_wr_addr = AW'(wa);
    d_tnew    = 2'(tn);
    e_flush   = fl;
    d_rd_data = {$urandom, $urandom};
    fwd_data  = {$urandom, $urandom, $urandom};
  endtask

  initial begin
    logic [DW-1:0] va;
    logic [DW-1:0] vb;
    reset = 1'b1;
`ifdef FWD_HAZARD_STALL_CNT_EN
    exp_cnt = 0;
`endif
    drive(1, 3, 0, 4, 0, 1, 3, 2, 0);
    hist_clear();
    @(posedge clk); #1;
    step("rst");
    reset = 1'b0;

    // Case 1: E-stage forward of an ALU result
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0); step("c1_iss");
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
    fwd_data[0 +: DW] = 32'h0000_0005;
    #1;
    chk("c1_sel", 32'(fwd_sel[0 +: SW]), 32'd1);
    chk("c1_op", operand[0 +: DW], 32'd5);
    chk("c1_stall", 32'(stall), 32'd0);
    step("c1");

    // Case 2: load-use stalls one cycle, then forwards from M
    drive(1, 0, 0, 0, 0, 1, 4, 1, 0); step("c2_iss");
    drive(1, 4, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("c2_stall_on", 32'(stall), 32'd1);
    step("c2_s");
    #1;
    chk("c2_stall_off", 32'(stall), 32'd0);
    chk("c2_sel", 32'(fwd_sel[0 +: SW]), 32'd2);
    va = fwd_data[DW +: DW];
    chk("c2_op", operand[0 +: DW], va);
    step("c2_go");

    // Case 3: youngest writer wins; both ports resolve identically
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0); step("c3_a");
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0); step("c3_b");
    drive(1, 5, 0, 5, 2, 0, 0, 0, 0);
    va = 32'hAAAA_0001; vb = 32'hBBBB_0002;
    fwd_data[0 +: DW] = va; fwd_data[DW +: DW] = vb;
    #1;
    chk("c3_sel0", 32'(fwd_sel[0 +: SW]), 32'd1);
    chk("c3_op0", operand[0 +: DW], va);
    chk("c3_sel1", 32'(fwd_sel[SW +: SW]), 32'd1);
    chk("c3_op1", operand[DW +: DW], va);
    step("c3");

    // Case 4: $0 never forwards or stalls
    drive(1, 0, 0, 0, 0, 1, 0, 2, 0); step("c4_iss");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("c4_stall", 32'(stall), 32'd0);
    chk("c4_sel", 32'(fwd_sel[0 +: SW]), 32'd0);
    va = d_rd_data[0 +: DW];
    chk("c4_op", operand[0 +: DW], va);
    step("c4");

    // Case 5: flushed producer leaves no hazard; reset cancels an active stall
    drive(1, 0, 0, 0, 0, 1, 6, 1, 1); step("c5_fl");
    drive(1, 6, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("c5_flush_stall", 32'(stall), 32'd0);
    step("c5_fl_rd");
    drive(1, 0, 0, 0, 0, 1, 6, 2, 0); step("c5_iss");
    drive(1, 6, 0, 6, 0, 0, 0, 0, 0);
    #1 chk("c5_pre_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    step("c5_rst");
    reset = 1'b0;
    #1;
    chk("c5_post_stall", 32'(stall), 32'd0);
    chk("c5_post_sel", 32'(fwd_sel), 32'd0);
    step("c5_post");

`ifdef FWD_HAZARD_STALL_CNT_EN
    // Case 6: three load-use stalls counted, then saturation
    reset = 1'b1; step("c6_rst"); reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      drive(1, 0, 0, 0, 0, 1, 7, 1, 0); step("c6_iss");
      drive(1, 7, 0, 0, 0, 0, 0, 0, 0); step("c6_stall");
      step("c6_go");
    end
    chk("c6_cnt3", stall_cnt, 32'd3);
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt;
    exp_cnt = 32'hFFFF_FFFF;
    drive(1, 0, 0, 0, 0, 1, 7, 1, 0); step("c6_iss_sat");
    drive(1, 7, 0, 0, 0, 0, 0, 0, 0); step("c6_stall_sat");
    chk("c6_sat", stall_cnt, 32'hFFFF_FFFF);
`endif

    // Randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 7) != 0,
            $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 9) == 0);
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the D-stage operand forwarding mux. It generalises to NUM_RD source ports and NUM_FWD downstream forwarding stages.
- Adds an internal destination scoreboard with Tnew tracking, and generates forward selects, forwarded operands and the D-stage stall.
- Sits between D-stage register-file read and the D/E pipeline register.
- Replaces separate per-operand muxes plus the external stall comparator.

Parameters:
- DATA_W, 32, operand/forward data width
- NUM_RD, 2, number of D-stage source read ports (rs, rt)
- NUM_FWD, 3, number of tracked downstream stages; index 0=E, 1=M, 2=W
- REG_AW, 5, register address width
- SEL_W, derived localparam = $clog2(NUM_FWD+1); not overridable

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- d_valid  in  1  D stage holds a real instruction
- d_rs_addr  in  NUM_RD*REG_AW  source register addresses, port i at [i*REG_AW +: REG_AW]
- d_tuse  in  NUM_RD*2  cycles until port i operand is consumed (0..3)
- d_rd_data  in  NUM_RD*DATA_W  register-file read data per port
- d_wr_en  in  1  D instruction writes a register
- d_wr_addr  in  REG_AW  D instruction destination register
- d_tnew  in  2  cycles after entering E until result is available (0..3)
- e_flush  in  1  insert bubble into E this cycle
- fwd_data  in  NUM_FWD*DATA_W  result value held in stage k at [k*DATA_W +: DATA_W]
- operand  out  NUM_RD*DATA_W  final operand per port
- fwd_sel  out  NUM_RD*SEL_W  0 = register file, k+1 = fwd_data[k]
- stall  out  1  freeze PC and F/D; bubble into E

Behaviour:
- Scoreboard entry per stage k holds {valid, wa, tnew}. Reset clears all valid bits to 0; wa and tnew are cleared to 0.
- On each clk edge (reset=0), the scoreboard shifts as follows:
  - entry[k+1] <= entry[k], with tnew = (tnew==0) ? 0 : tnew-1. The last entry falls off.
  - entry[0] <= bubble (valid=0) if stall | e_flush | !d_valid.
  - Otherwise entry[0] <= {d_wr_en && d_wr_addr!=0, d_wr_addr, d_tnew}.
- Lookup per port i (combinational, zero latency), with a = port address and u = port tuse:
  - If a==0 or no valid entry matches: fwd_sel=0, operand=d_rd_data[i], no stall from this port.
  - Otherwise take the youngest match (smallest k). Older matching entries are ignored.
  - Youngest match with tnew==0: fwd_sel=k+1, operand=fwd_data[k].
  - Youngest match with tnew>0 and tnew<=u: fwd_sel=0, operand=d_rd_data[i], no stall. A later-stage mux resolves it.
  - Youngest match with tnew>u: port stall request.
- stall = d_valid & OR(port stall requests). Stall is purely combinational from the current scoreboard and D inputs.
- A stall inserts exactly one bubble per cycle. Because Tnew decrements monotonically, stall always self-clears within 3 cycles.
- Simultaneous stall and e_flush: a bubble is inserted once, with no other difference.
- Reset mid-stall: the scoreboard clears on the next edge and stall drops the same cycle after reset.
- Outputs during reset follow the combinational rules on the cleared scoreboard: fwd_sel=0, operand=d_rd_data, stall=0.
- Two ports reading the same register resolve independently and identically.

Optional Feature:
- Macro: FWD_HAZARD_STALL_CNT_EN
- Defined: adds output stall_cnt [31:0].
  - Counts clock cycles with stall==1.
  - Resets to 0 on reset.
  - Saturates at 32'hFFFFFFFF; no wrap.
- Undefined: port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- Case 1, add-add E forward.
  - Stimulus: issue addu $3 (d_tnew=0). Next cycle read $3 on port 0 with tuse=1; fwd_data[0]=32'h0000_0005.
  - Required: fwd_sel[0]=1, operand[0]=5, stall=0.
- Case 2, load-use.
  - Stimulus: issue lw $4 (d_tnew=1). Next cycle beq reads $4 with tuse=0.
  - Required: stall=1 for exactly 1 cycle. Then fwd_sel=2 (M) with operand = fwd_data[1].
- Case 3, youngest wins.
  - Stimulus: addu $5 at M (tnew=0), then addu $5 at E (tnew=0); fwd_data[0]=A, fwd_data[1]=B.
  - Required: fwd_sel=1, operand=A.
- Case 4, $0 rule.
  - Stimulus: issue an instruction writing $0 with tnew=2, then read $0 with tuse=0.
  - Required: no stall, fwd_sel=0, operand=d_rd_data.
- Case 5, flush/reset.
  - Stimulus: issue lw $6 with e_flush=1. Next cycle read $6 with tuse=0.
  - Required: stall=0. Separately, assert reset during an active stall: stall=0 and all fwd_sel=0 after the edge.
- Case 6, stall counter (macro defined).
  - Stimulus: 3 load-use stalls.
  - Required: stall_cnt=3. Preload 32'hFFFFFFFF via force; a further stall leaves it unchanged.
